// File: rtl/alu_frame_loader.sv
// Serial frame loader: SYNC, A, B, OP bytes feed the ALU operand registers.
// Starts the operation and waits for completion, with an inter-byte timeout.
module alu_frame_loader #(
  parameter int                 NB_DATA        = 8,
  parameter logic [NB_DATA-1:0] SYNC_BYTE      = 8'hA5,
  parameter int                 TIMEOUT_CYCLES = 1000
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_valid,
  input  logic               i_done,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_en_a,
  output logic               o_en_b,
  output logic               o_en_op,
  output logic               o_start,
  output logic               o_busy,
  output logic               o_err
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    GET_A,
    GET_B,
    GET_OP,
    START,
    WAIT_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [NB_DATA-1:0] data_q, data_d;
  logic               en_a_q, en_a_d;
  logic               en_b_q, en_b_d;
  logic               en_op_q, en_op_d;
  logic               start_q, start_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    en_a_d  = 1'b0;
    en_b_d  = 1'b0;
    en_op_d = 1'b0;
    start_d = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_rx_valid && (i_rx_data == SYNC_BYTE)) begin
          state_d = GET_A;
          cnt_d   = '0;
        end
      end
      GET_A, GET_B, GET_OP: begin
        // A byte on the last allowed cycle still wins over the timeout.
        if (i_rx_valid) begin
          data_d = i_rx_data;
          cnt_d  = '0;
          if (state_q == GET_A) begin
            en_a_d  = 1'b1;
            state_d = GET_B;
          end else if (state_q == GET_B) begin
            en_b_d  = 1'b1;
            state_d = GET_OP;
          end else begin
            en_op_d = 1'b1;
            state_d = START;
          end
        end else if (cnt_q == CNT_MAX) begin
          state_d = IDLE;
          err_d   = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      START: begin
        start_d = 1'b1;
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (i_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      en_a_q  <= 1'b0;
      en_b_q  <= 1'b0;
      en_op_q <= 1'b0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      en_a_q  <= en_a_d;
      en_b_q  <= en_b_d;
      en_op_q <= en_op_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign o_data  = data_q;
  assign o_en_a  = en_a_q;
  assign o_en_b  = en_b_q;
  assign o_en_op = en_op_q;
  assign o_start = start_q;
  assign o_busy  = busy_q;
  assign o_err   = err_q;

endmodule

// File: doc/alu_frame_loader.md
ALU_FRAME_LOADER -- requirements
Module: alu_frame_loader

Interface
REQ-001 Parameter NB_DATA, default 8, shall set the width of the received byte and of o_data.
REQ-002 Parameter SYNC_BYTE, default 8'hA5, shall be the frame header value.
REQ-003 Parameter TIMEOUT_CYCLES, default 1000, shall be the maximum idle gap allowed between bytes inside a frame; legal range is >= 2.
REQ-004 Port i_clk, input, 1 bit, shall be the single clock; all state changes on its rising edge.
REQ-005 Port i_rst, input, 1 bit, shall be the synchronous, active-high reset.
REQ-006 Port i_rx_data, input, NB_DATA bits, shall carry the received byte.
REQ-007 Port i_rx_valid, input, 1 bit, shall be a one-cycle strobe qualifying i_rx_data.
REQ-008 Port i_done, input, 1 bit, shall be the downstream completion strobe for the started operation.
REQ-009 Port o_data, output, NB_DATA bits, shall be the registered byte presented to the downstream enabled registers.
REQ-010 Ports o_en_a, o_en_b and o_en_op, outputs, 1 bit each, shall be the load enables for the operand-A, operand-B and opcode registers.
REQ-011 Port o_start, output, 1 bit, shall pulse once per complete frame.
REQ-012 Port o_busy, output, 1 bit, shall be high while a frame is in progress or awaiting i_done.
REQ-013 Port o_err, output, 1 bit, shall pulse for one cycle on a frame timeout.

Function
REQ-014 The FSM states shall be IDLE, GET_A, GET_B, GET_OP, START and WAIT_DONE.
REQ-015 In IDLE, a byte with i_rx_valid=1 and i_rx_data==SYNC_BYTE shall move the FSM to GET_A; any other byte shall be discarded with no output activity.
REQ-016 In GET_A, GET_B and GET_OP, each valid byte shall be registered into o_data and shall advance the FSM to GET_B, GET_OP and START respectively.
REQ-017 In the cycle after a byte is accepted in GET_A, GET_B or GET_OP, exactly one of o_en_a, o_en_b or o_en_op shall be high for one cycle, with o_data equal to that byte.
REQ-018 o_data shall hold its last value whenever no byte is being accepted.
REQ-019 START shall last one cycle, assert o_start=1 during that cycle, and then go to WAIT_DONE.
REQ-020 Because of REQ-019, o_start shall be high in the cycle after o_en_op.
REQ-021 WAIT_DONE shall ignore i_rx_valid and shall return to IDLE on i_done=1.
REQ-022 i_done in any state other than WAIT_DONE shall be ignored.
REQ-023 o_busy shall be 1 in GET_A, GET_B, GET_OP, START and WAIT_DONE, and 0 in IDLE.
REQ-024 A timeout counter shall clear on entry to GET_A and on every accepted byte, and shall increment each cycle in GET_A, GET_B and GET_OP.
REQ-025 When the timeout counter reaches TIMEOUT_CYCLES-1 with no valid byte that cycle, the FSM shall go to IDLE, o_err shall pulse 1 cycle, and no enable shall assert.
REQ-026 If a valid byte arrives in the same cycle the counter reaches TIMEOUT_CYCLES-1, the byte shall win: it is accepted and the counter clears.
REQ-027 A SYNC_BYTE value received in GET_A, GET_B or GET_OP shall be treated as data, not as a resync.
REQ-028 The counter width shall be clog2(TIMEOUT_CYCLES), and the counter shall never wrap.

Reset
REQ-029 On i_rst=1 at a clock edge, the FSM shall go to IDLE, regardless of current state.
REQ-030 On reset, o_data shall become 0; o_en_a, o_en_b, o_en_op, o_start, o_busy and o_err shall become 0; and the timeout counter shall become 0.
REQ-031 Reset mid-frame shall discard the partial frame, with no enable or o_err pulse in the following cycle.
REQ-032 i_rst shall take priority over i_rx_valid and i_done in the same cycle.

Verification
REQ-033 Nominal frame: bytes A5, 12, 34, 05 on consecutive cycles -> o_en_a with o_data=12, then o_en_b with 34, then o_en_op with 05, then o_start, each on the cycle after its byte; o_busy=1 until i_done.
REQ-034 Junk in IDLE: bytes 00, FF, 5A -> no enables, o_busy=0; then A5 -> o_busy=1 next cycle.
REQ-035 Timeout with TIMEOUT_CYCLES=8: A5, 12, then silence -> o_err pulse 8 cycles after 12 is accepted, FSM back in IDLE, no o_en_b.
REQ-036 Boundary: byte arrives on the cycle the counter reaches 7 -> byte accepted, no o_err.
REQ-037 Busy lockout: a complete frame followed by bytes A5, 01 before i_done -> no enables; after i_done, a new frame loads normally.
REQ-038 Reset asserted in GET_B -> all outputs 0 next cycle; a following A5, 12, 34, 05 frame completes normally.
